// File: rtl/seq_divider_pkg.sv
// Shared encodings for the iterative divider: M-extension divide op codes and FSM states.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module seq_divider_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem,
    input  logic            q_msb,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] rem_shift;

    // The shifted remainder needs XLEN+1 bits; after a successful subtract it is below dvs again.
    assign rem_shift = {rem, q_msb};
    assign q_bit     = (rem_shift >= {1'b0, dvs});
    assign rem_next  = q_bit ? (rem_shift[XLEN-1:0] - dvs) : rem_shift[XLEN-1:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with start/ready handshake and kill.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    div_state_e      state, state_next;
    logic            is_rem, neg_q, neg_r;
    logic [XLEN-1:0] dvs, quo, rem;
    logic [CW-1:0]   cnt;

    logic            is_signed, a_neg, b_neg, div_zero, ovf, special, accept;
    logic [XLEN-1:0] a_abs, b_abs, special_res, rem_next;
    logic            q_bit;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & dividend[XLEN-1];
    assign b_neg     = is_signed & divisor[XLEN-1];
    assign a_abs     = a_neg ? -dividend : dividend;
    assign b_abs     = b_neg ? -divisor  : divisor;
    assign div_zero  = (divisor == '0);
    assign ovf       = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
    assign special   = div_zero | ovf;
    // RISC-V results: x/0 gives all ones and remainder x; MIN/-1 gives MIN and remainder 0.
    assign special_res = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);

    assign ready  = (state == S_IDLE) || (state == S_DONE);
    assign done   = (state == S_DONE);
    assign accept = ready & start & ~kill;

    seq_divider_step #(.XLEN(XLEN)) u_step (
        .rem      (rem),
        .q_msb    (quo[XLEN-1]),
        .dvs      (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // NOTE: state_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start)           state_next = special ? S_DONE : S_CALC;
                else if (state == S_DONE) state_next = S_IDLE;
            end
            S_CALC:  if (cnt == '0) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (kill) state_next = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rem <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dvs    <= '0;
            quo    <= '0;
            rem    <= '0;
            cnt    <= '0;
            result <= '0;
        end else if (!kill) begin
            if (accept) begin
                is_rem <= op[1];
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dvs    <= b_abs;
                quo    <= a_abs;
                rem    <= '0;
                cnt    <= CW'(XLEN-1);
                if (special) result <= special_res;
            end else if (state == S_CALC) begin
                // quo doubles as the dividend shifter: its MSB feeds the step, quotient bits enter at the LSB.
                rem <= rem_next;
                quo <= {quo[XLEN-2:0], q_bit};
                cnt <= cnt - 1'b1;
            end else if (state == S_FIX) begin
                if (is_rem) result <= neg_r ? -rem : rem;
                else        result <= neg_q ? -quo : quo;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (XLEN=64): directed spec cases plus randomized ops vs an arithmetic model.
module tb_seq_divider;

    localparam int XLEN = 64;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] dividend = '0;
    logic [XLEN-1:0] divisor = '0;
    logic            kill = 1'b0;
    logic            ready, done;
    logic [XLEN-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    seq_divider #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .kill     (kill),
        .ready    (ready),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: plain Verilog / and % with the RISC-V special cases taken first.
    function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        longint sa, sb;
        if (b == 64'd0) return o[1] ? a : ONES;
        if (!o[0]) begin
            if (a == MIN && b == ONES) return o[1] ? 64'd0 : MIN;
            sa = $signed(a);
            sb = $signed(b);
            return o[1] ? 64'(sa % sb) : 64'(sa / sb);
        end
        return o[1] ? a % b : a / b;
    endfunction

    function automatic int ref_lat(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        if (b == 64'd0 || (!o[0] && a == MIN && b == ONES)) return 0;
        return XLEN + 1;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge (cyc = 0).
    task automatic issue(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        start = 1'b1;
        op = o;
        dividend = a;
        divisor = b;
        check("ready_at_start", 64'(ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_done(input string tag, input logic [63:0] exp, input int exp_lat);
        while (!done && cyc < 200) tick();
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check(tag, result, exp);
        if (exp_lat == 0) check({tag, "_ready"}, 64'(ready), 64'd1);
    endtask

    task automatic run_exp(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int exp_lat, input string tag);
        issue(o, a, b);
        wait_done(tag, exp, exp_lat);
        tick();
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    initial begin
        logic [63:0] prev, a, b;
        logic [1:0]  o;
        bit seen;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", result, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_exp(2'b01, 64'd100, 64'd7, 64'd14, 65, "divu_100_7");
        run_exp(2'b11, 64'd100, 64'd7, 64'd2, 65, "remu_100_7");
        run_exp(2'b00, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, "div_m7_2");
        run_exp(2'b10, -64'sd7, 64'd2, ONES, 65, "rem_m7_2");
        run_exp(2'b10, 64'd7, -64'sd2, 64'd1, 65, "rem_7_m2");
        run_exp(2'b01, 64'd5, 64'd0, ONES, 0, "divu_by0");
        run_exp(2'b10, 64'd5, 64'd0, 64'd5, 0, "rem_by0");
        run_exp(2'b00, MIN, ONES, MIN, 0, "div_ovf");
        run_exp(2'b10, MIN, ONES, 64'd0, 0, "rem_ovf");

        // Kill mid-calculation: no done, result unchanged.
        prev = result;
        issue(2'b01, 64'd1000, 64'd3);
        while (cyc < 19) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_ready", 64'(ready), 64'd1);
        check("kill_done", 64'(done), 64'd0);
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (done) seen = 1'b1;
        end
        check("kill_no_done", 64'(seen), 64'd0);
        check("kill_result_kept", result, prev);
        run_exp(2'b01, 64'd9, 64'd3, 64'd3, 65, "divu_9_3");

        // start during CALC must be ignored.
        issue(2'b01, 64'd100, 64'd7);
        repeat (5) begin
            tick();
            start = 1'b1;
            op = 2'(($urandom_range(0, 3)));
            dividend = {$urandom, $urandom};
            divisor = {$urandom, $urandom};
        end
        tick();
        start = 1'b0;
        wait_done("calc_start_ignored", 64'd14, 65);

        // Back-to-back: new start raised on the done cycle.
        issue(2'b00, -64'sd7, 64'd2);
        check("b2b_ready_low", 64'(ready), 64'd0);
        check("b2b_done_low", 64'(done), 64'd0);
        wait_done("b2b_second", 64'hFFFF_FFFF_FFFF_FFFD, 65);
        tick();

        // Asynchronous reset mid-CALC.
        issue(2'b00, 64'd12345, 64'd67);
        repeat (10) tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ready", 64'(ready), 64'd1);
        check("arst_done", 64'(done), 64'd0);
        check("arst_result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized ops, mixing back-to-back starts and idle gaps.
        for (int i = 0; i < 600; i++) begin
            o = 2'($urandom_range(0, 3));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 6))
                0: b = 64'($urandom_range(1, 20));
                1: b = 64'd0;
                2: begin a = MIN; b = ONES; end
                3: b = ONES;
                4: a = 64'($urandom_range(0, 1000));
                5: b = b >> $urandom_range(0, 63);
                default: ;
            endcase
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
            issue(o, a, b);
            wait_done($sformatf("rand%0d_op%0d", i, o), ref_res(o, a, b), ref_lat(o, a, b));
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
